hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 16-bit RISC core.
- Drives the IF/ID pipeline register's hold (if_id_write) and flush (if_flush) controls, the PC write enable and PC source select, and the ID/EX bubble insert.
- Handles load-use stalls, taken-branch flushes lasting several cycles, data-memory wait stalls, and HALT/resume.
- Sits beside the IF/ID buffer and is fed by ID decode and EX resolution.

Parameters:
ADDR_W, 6, instruction address width (informational; pc_sel_branch only selects the source)
REG_AW, 3, register-specifier width; register 0 is hardwired zero
FLUSH_CYCLES, 2, total cycles if_flush is asserted per taken branch, counting the branch cycle; legal range 1..7
CNT_W, 16, width of the stall performance counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs  in  REG_AW  source register A of the instruction in ID
id_rt  in  REG_AW  source register B of the instruction in ID
id_uses_rt  in  1  instruction in ID reads id_rt
ex_mem_read  in  1  instruction in ID/EX is a load
ex_rd  in  REG_AW  destination register of the instruction in ID/EX
branch_taken  in  1  EX resolved a taken branch; level, valid while the branch sits in EX
mem_busy  in  1  data memory not ready; freezes the whole pipe
halt_dec  in  1  HALT decoded in ID
resume  in  1  restart request after HALT
pc_write  out  1  1 = PC loads its next value
if_id_write  out  1  1 = IF/ID buffer HOLDS its contents (the buffer's native polarity)
if_flush  out  1  1 = IF/ID buffer loads zero (NOP)
id_ex_bubble  out  1  1 = ID/EX loads a NOP
pc_sel_branch  out  1  1 = PC source is the branch target
state  out  2  current FSM state
stall_count  out  CNT_W  cycles with pc_write=0 since reset, saturating

Behaviour:
- Registers: state, flush counter fcnt (3 bits), stall_count. All outputs other than state and stall_count are combinational from state, fcnt and inputs.
- Reset (reset_n=0, asynchronous):
  - state=RUN, fcnt=0, stall_count=0.
  - Outputs forced: pc_write=0, if_id_write=0, if_flush=1, id_ex_bubble=1, pc_sel_branch=0.
  - Reset during FLUSH or HALTED aborts to RUN.
- load_use = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Default outputs: pc_write=1; all others 0.
- States: RUN=0, FLUSH=1, MEM_WAIT=2, HALTED=3.
- RUN / MEM_WAIT rules, evaluated in priority order:
  1. mem_busy: pc_write=0, if_id_write=1, id_ex_bubble=0. Next state MEM_WAIT. branch_taken is ignored, because EX is frozen and the branch is re-presented.
  2. branch_taken: pc_sel_branch=1, pc_write=1, if_flush=1, id_ex_bubble=1. If FLUSH_CYCLES>1, next FLUSH with fcnt=FLUSH_CYCLES-1; otherwise next RUN.
  3. load_use: pc_write=0, if_id_write=1, id_ex_bubble=1. Next RUN. The hazard clears naturally after one cycle.
  4. halt_dec: pc_write=0, if_id_write=1, id_ex_bubble=1. Next HALTED.
  5. Otherwise: defaults, next RUN.
  - MEM_WAIT with mem_busy=0 behaves exactly as RUN, including its transitions.
- FLUSH:
  - Outputs: if_flush=1, id_ex_bubble=1, pc_write=1.
  - fcnt decrements; at fcnt==1 the next state is RUN.
  - If mem_busy: pc_write=0, fcnt holds, if_flush stays 1.
  - branch_taken, load_use and halt_dec are ignored; those instructions are being squashed.
- HALTED:
  - Outputs: pc_write=0, if_id_write=1, id_ex_bubble=1.
  - resume=1 gives next state RUN; outputs stay halted during the resume cycle.
  - branch_taken is ignored.
- Simultaneous events:
  - branch_taken together with load_use or halt_dec: the branch wins, and the ID instruction is flushed.
  - mem_busy beats everything else.
- stall_count: +1 on each clock with reset_n=1 and pc_write=0; saturates at all-ones with no wrap.

Test Plan:
1. Reset, then idle inputs → pc_write=1, if_id_write=0, if_flush=0, state=0, stall_count=0.
2. ex_mem_read=1, ex_rd=3, id_rs=3 for one cycle → exactly 1 cycle with pc_write=0, if_id_write=1, id_ex_bubble=1; stall_count=1. Repeat with ex_rd=0 → no stall.
3. branch_taken pulse with FLUSH_CYCLES=2 → cycle 0: pc_sel_branch=1, if_flush=1; cycle 1: state=FLUSH, if_flush=1; cycle 2: RUN. Repeat with FLUSH_CYCLES=3 → 3 flush cycles.
4. branch_taken and load_use asserted in the same cycle → flush behaviour; no hold; stall_count unchanged.
5. mem_busy asserted for 4 cycles during FLUSH (fcnt=1) → pc_write=0 for 4 cycles, fcnt held; FLUSH completes afterwards; stall_count +4.
6. halt_dec, then resume after 5 cycles → HALTED with pc_write=0 for 6 cycles, then RUN; reset_n pulsed low mid-HALT → immediate RUN and counters cleared.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// Hazard and sequencing controller for the 16-bit RISC core: load-use stalls,
// multi-cycle branch flushes, data-memory wait freezes and HALT/resume.
module hazard_flush_ctrl #(
    parameter int ADDR_W       = 6,
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              halt_dec,
    input  logic              resume,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_flush,
    output logic              id_ex_bubble,
    output logic              pc_sel_branch,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_e;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || ADDR_W < 1) begin : gBadParams
        $error("hazard_flush_ctrl: FLUSH_CYCLES must be 1..7 and ADDR_W positive");
    end

    localparam logic [2:0] FcntLoad = 3'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stallCount_q;

    logic loadUse;
    logic pcWrite, holdIfId, flushIfId, bubble, selBranch;

    assign loadUse = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pcWrite   = 1'b1;
        holdIfId  = 1'b0;
        flushIfId = 1'b0;
        bubble    = 1'b0;
        selBranch = 1'b0;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                // A frozen EX re-presents its branch, so mem_busy must shadow it.
                if (mem_busy) begin
                    pcWrite  = 1'b0;
                    holdIfId = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (branch_taken) begin
                    selBranch = 1'b1;
                    flushIfId = 1'b1;
                    bubble    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FcntLoad;
                    end else begin
                        state_d = RUN;
                    end
                end else if (loadUse) begin
                    pcWrite  = 1'b0;
                    holdIfId = 1'b1;
                    bubble   = 1'b1;
                    state_d  = RUN;
                end else if (halt_dec) begin
                    pcWrite  = 1'b0;
                    holdIfId = 1'b1;
                    bubble   = 1'b1;
                    state_d  = HALTED;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                flushIfId = 1'b1;
                bubble    = 1'b1;
                if (mem_busy) begin
                    pcWrite = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            HALTED: begin
                pcWrite  = 1'b0;
                holdIfId = 1'b1;
                bubble   = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // While reset is low the pipe is held in a safe NOP-injecting configuration.
    assign pc_write      = reset_n & pcWrite;
    assign if_id_write   = reset_n & holdIfId;
    assign if_flush      = ~reset_n | flushIfId;
    assign id_ex_bubble  = ~reset_n | bubble;
    assign pc_sel_branch = reset_n & selBranch;
    assign state         = state_q;
    assign stall_count   = stallCount_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            fcnt_q       <= 3'd0;
            stallCount_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (!pc_write && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed scoreboard bench for hazard_flush_ctrl: a default instance plus a
// FLUSH_CYCLES=3 / 3-bit counter instance for flush length and saturation.
module tb_hazard_flush_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy, halt_dec, resume;

    logic        pc_write, if_id_write, if_flush, id_ex_bubble, pc_sel_branch;
    logic [1:0]  state;
    logic [15:0] stall_count;

    logic        bPcWrite, bIfIdWrite, bIfFlush, bBubble, bSel;
    logic [1:0]  bState;
    logic [2:0]  bStallCount;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        pcw, hold, flush, bub, sel;
        logic [1:0]  st;
        logic [15:0] cnt;
    } expA_t;

    typedef struct {
        logic [1:0] st;
        logic       flush, sel;
        logic [2:0] cnt;
    } expB_t;

    expA_t expQ[$];
    expB_t expBQ[$];

    hazard_flush_ctrl #(.ADDR_W(6), .REG_AW(3), .FLUSH_CYCLES(2), .CNT_W(16)) dutA (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .halt_dec(halt_dec), .resume(resume),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .id_ex_bubble(id_ex_bubble), .pc_sel_branch(pc_sel_branch),
        .state(state), .stall_count(stall_count)
    );

    hazard_flush_ctrl #(.ADDR_W(6), .REG_AW(3), .FLUSH_CYCLES(3), .CNT_W(3)) dutB (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .halt_dec(halt_dec), .resume(resume),
        .pc_write(bPcWrite), .if_id_write(bIfIdWrite), .if_flush(bIfFlush),
        .id_ex_bubble(bBubble), .pc_sel_branch(bSel),
        .state(bState), .stall_count(bStallCount)
    );

    always #5 clock = ~clock;

    task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expA_t e;
        e = expQ.pop_front();
        compare("pc_write", 16'(pc_write), 16'(e.pcw));
        compare("if_id_write", 16'(if_id_write), 16'(e.hold));
        compare("if_flush", 16'(if_flush), 16'(e.flush));
        compare("id_ex_bubble", 16'(id_ex_bubble), 16'(e.bub));
        compare("pc_sel_branch", 16'(pc_sel_branch), 16'(e.sel));
        compare("state", 16'(state), 16'(e.st));
        compare("stall_count", stall_count, e.cnt);
    endtask

    task automatic checkOutputB();
        expB_t e;
        e = expBQ.pop_front();
        compare("B.state", 16'(bState), 16'(e.st));
        compare("B.if_flush", 16'(bIfFlush), 16'(e.flush));
        compare("B.pc_sel_branch", 16'(bSel), 16'(e.sel));
        compare("B.stall_count", 16'(bStallCount), 16'(e.cnt));
    endtask

    // Inputs are already driven at the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic pcw, input logic hold, input logic flush,
                                 input logic bub, input logic sel, input logic [1:0] st,
                                 input logic [15:0] cnt);
        expA_t e;
        e.pcw = pcw; e.hold = hold; e.flush = flush; e.bub = bub; e.sel = sel;
        e.st = st; e.cnt = cnt;
        expQ.push_back(e);
        #1;
        checkOutput();
        @(negedge clock);
    endtask

    task automatic applyStimulusB(input logic [1:0] st, input logic flush, input logic sel,
                                  input logic [2:0] cnt);
        expB_t e;
        e.st = st; e.flush = flush; e.sel = sel; e.cnt = cnt;
        expBQ.push_back(e);
        #1;
        checkOutputB();
        @(negedge clock);
    endtask

    task automatic clearInputs();
        id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
        mem_busy = 1'b0; halt_dec = 1'b0; resume = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        clearInputs();
        // Reset forces the safe output pattern.
        applyStimulus(0, 0, 1, 1, 0, 2'd0, 16'd0);
        reset_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd0);

        // Load-use via rs, then ex_rd=0 (no stall), then via rt.
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
        applyStimulus(0, 1, 0, 1, 0, 2'd0, 16'd0);
        clearInputs();
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd1);
        ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs = 3'd0;
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd1);
        ex_mem_read = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1; id_rs = 3'd2;
        applyStimulus(0, 1, 0, 1, 0, 2'd0, 16'd1);
        id_uses_rt = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd2);
        clearInputs();

        // Taken branch with two flush cycles.
        branch_taken = 1'b1;
        applyStimulus(1, 0, 1, 1, 1, 2'd0, 16'd2);
        clearInputs();
        applyStimulus(1, 0, 1, 1, 0, 2'd1, 16'd2);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd2);

        // Branch beats a simultaneous load-use; events in FLUSH are ignored.
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
        applyStimulus(1, 0, 1, 1, 1, 2'd0, 16'd2);
        halt_dec = 1'b1;
        applyStimulus(1, 0, 1, 1, 0, 2'd1, 16'd2);
        clearInputs();
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd2);

        // mem_busy for four cycles while FLUSH holds fcnt=1.
        branch_taken = 1'b1;
        applyStimulus(1, 0, 1, 1, 1, 2'd0, 16'd2);
        clearInputs();
        mem_busy = 1'b1;
        applyStimulus(0, 0, 1, 1, 0, 2'd1, 16'd2);
        applyStimulus(0, 0, 1, 1, 0, 2'd1, 16'd3);
        applyStimulus(0, 0, 1, 1, 0, 2'd1, 16'd4);
        applyStimulus(0, 0, 1, 1, 0, 2'd1, 16'd5);
        mem_busy = 1'b0;
        applyStimulus(1, 0, 1, 1, 0, 2'd1, 16'd6);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd6);

        // mem_busy beats a branch; the branch is taken from MEM_WAIT afterwards.
        mem_busy = 1'b1; branch_taken = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 2'd0, 16'd6);
        mem_busy = 1'b0;
        applyStimulus(1, 0, 1, 1, 1, 2'd2, 16'd7);
        clearInputs();
        applyStimulus(1, 0, 1, 1, 0, 2'd1, 16'd7);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd7);

        // HALT, four idle halted cycles (one with a branch), then resume.
        halt_dec = 1'b1;
        applyStimulus(0, 1, 0, 1, 0, 2'd0, 16'd7);
        halt_dec = 1'b0;
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 16'd8);
        branch_taken = 1'b1;
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 16'd9);
        branch_taken = 1'b0;
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 16'd10);
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 16'd11);
        resume = 1'b1;
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 16'd12);
        resume = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd13);

        // Reset in the middle of HALTED returns to RUN with counters cleared.
        halt_dec = 1'b1;
        applyStimulus(0, 1, 0, 1, 0, 2'd0, 16'd13);
        halt_dec = 1'b0;
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 16'd14);
        reset_n = 1'b0;
        applyStimulus(0, 0, 1, 1, 0, 2'd0, 16'd0);
        reset_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 16'd0);

        // Three-cycle flush and counter saturation on the second instance.
        branch_taken = 1'b1;
        applyStimulusB(2'd0, 1, 1, 3'd0);
        branch_taken = 1'b0;
        applyStimulusB(2'd1, 1, 0, 3'd0);
        applyStimulusB(2'd1, 1, 0, 3'd0);
        applyStimulusB(2'd0, 0, 0, 3'd0);
        halt_dec = 1'b1;
        applyStimulusB(2'd0, 0, 0, 3'd0);
        halt_dec = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulusB(2'd3, 0, 0, (i + 1 > 7) ? 3'd7 : 3'(i + 1));
        end
        resume = 1'b1;
        applyStimulusB(2'd3, 0, 0, 3'd7);
        resume = 1'b0;
        applyStimulusB(2'd0, 0, 0, 3'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
